// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Registered FETCH/DECODE/EXEC/MEM/WB sequencer for the 19-bit CPU. The
// opcode is captured on the fetch handshake. Every datapath strobe is then
// decoded combinationally from the current state, the captured opcode, the
// ALU zero flag and the data-memory ready line. The unit also tracks the
// hardware call-stack depth, and halts on stack overflow, stack underflow or
// an illegal opcode. Only reset leaves the halt.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr_valid, op   fetched instruction handshake and its opcode
//   instr_ready       high in FETCH: an instruction is accepted this cycle
//   zero              ALU zero flag, consulted only by BEQ/BNE in EXEC
//   mem_ready         data memory finishes its access this cycle (MEM only)
//   ir_write          load instruction register
//   pc_write, pc_src  PC update strobe and source select
//                     (00 PC+1, 01 branch, 10 jump, 11 stack top)
//   reg_write, alu_src, mem_read, mem_write, result_src  datapath strobes
//   imm_src           immediate format (00 none, 01 I/S/B, 10 J)
//   alu_op            ALU operation select, fixed at 00
//   stack_push, stack_pop  hardware call-stack strobes
//   depth             current call depth
//   fault             high while halted
module multicycle_control_unit #(
    parameter int OP_W        = 5,
    parameter int STACK_DEPTH = 8,
    localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            instr_ready,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg_write,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            result_src,
    output logic [1:0]      imm_src,
    output logic [1:0]      alu_op,
    output logic            stack_push,
    output logic            stack_pop,
    output logic [DW-1:0]   depth,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_R     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CALL  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RET   = OP_W'(7);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [DW-1:0]   depth_q, depth_d;

    logic            op_legal;
    logic [1:0]      imm_sel;

    // Opcodes above RET are not part of the instruction set.
    assign op_legal = (op_q <= OP_RET);
    assign alu_op   = 2'b00;
    assign depth    = depth_q;

    // DECODE and EXEC present the same immediate format.
    always_comb begin
        imm_sel = 2'b00;
        case (op_q)
            OP_LOAD, OP_STORE, OP_BEQ, OP_BNE: imm_sel = 2'b01;
            OP_JMP, OP_CALL:                   imm_sel = 2'b10;
            default:                           imm_sel = 2'b00;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        reg_write   = 1'b0;
        alu_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        result_src  = 1'b0;
        imm_src     = 2'b00;
        stack_push  = 1'b0;
        stack_pop   = 1'b0;
        fault       = 1'b0;
        state_d     = state_q;
        op_d        = op_q;
        depth_d     = depth_q;

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_write = 1'b1;
                    op_d     = op;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                imm_src = imm_sel;
                state_d = op_legal ? S_EXEC : S_HALT;
            end

            S_EXEC: begin
                imm_src = imm_sel;
                state_d = S_FETCH;
                case (op_q)
                    OP_R: state_d = S_WB;
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = zero ? 2'b01 : 2'b00;
                    end
                    OP_BNE: begin
                        pc_write = 1'b1;
                        pc_src   = zero ? 2'b00 : 2'b01;
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                    OP_CALL: begin
                        // A full stack faults rather than overwriting the bottom entry.
                        if (depth_q == DEPTH_MAX) begin
                            state_d = S_HALT;
                        end else begin
                            stack_push = 1'b1;
                            pc_write   = 1'b1;
                            pc_src     = 2'b10;
                            depth_d    = depth_q + DW'(1);
                        end
                    end
                    OP_RET: begin
                        if (depth_q == '0) begin
                            state_d = S_HALT;
                        end else begin
                            stack_pop = 1'b1;
                            pc_write  = 1'b1;
                            pc_src    = 2'b11;
                            depth_d   = depth_q - DW'(1);
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end

            S_MEM: begin
                alu_src = 1'b1;
                imm_src = 2'b01;
                if (op_q == OP_LOAD) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB;
                    end
                end else begin
                    // A store has no writeback, so it retires from MEM.
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                result_src = (op_q == OP_LOAD);
                state_d    = S_FETCH;
            end

            S_HALT: begin
                fault   = 1'b1;
                state_d = S_HALT;
            end

            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. A driver issues instructions
// with random stalls, memory waits and zero flags. For each instruction it
// pushes the expected retirement (or halt) record, which comes from a
// per-opcode model of cycle counts and strobe counts. A monitor pops and
// compares whenever the DUT retires an instruction (pc_write) or halts.
module tb_multicycle_control_unit;

    localparam int OP_W = 5;
    localparam int SD   = 4;
    localparam int DW   = $clog2(SD + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic [OP_W-1:0] op;
    logic            zero;
    logic            mem_ready;
    logic            instr_ready, ir_write, pc_write;
    logic [1:0]      pc_src;
    logic            reg_write, alu_src, mem_read, mem_write, result_src;
    logic [1:0]      imm_src, alu_op;
    logic            stack_push, stack_pop;
    logic [DW-1:0]   depth;
    logic            fault;

    multicycle_control_unit #(.OP_W(OP_W), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .zero(zero),
        .mem_ready(mem_ready), .instr_ready(instr_ready), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .result_src(result_src), .imm_src(imm_src), .alu_op(alu_op),
        .stack_push(stack_push), .stack_pop(stack_pop), .depth(depth),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit halt;
        int cycles;
        int pc_src;
        int n_ready, n_irw, n_rd, n_wr, n_reg, n_res;
        int n_alu, n_imm1, n_imm2, n_push, n_pop;
        int depth_pre;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   model_depth = 0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Expected behaviour of one instruction, derived from opcode semantics.
    function automatic exp_t model(input int opc, input int s, input int w,
                                   input bit z, input int d);
        exp_t e = '{default: 0};
        e.n_ready = s + 1;
        e.n_irw = 1;
        e.depth_pre = d;
        case (opc)
            0: begin e.cycles = 4; e.n_reg = 1; end
            1: begin e.cycles = 5 + w; e.n_rd = w + 1; e.n_reg = 1; e.n_res = 1;
                     e.n_alu = w + 2; e.n_imm1 = w + 3; end
            2: begin e.cycles = 4 + w; e.n_wr = w + 1; e.n_alu = w + 2; e.n_imm1 = w + 3; end
            3: begin e.cycles = 3; e.n_imm1 = 2; e.pc_src = z ? 1 : 0; end
            4: begin e.cycles = 3; e.n_imm1 = 2; e.pc_src = z ? 0 : 1; end
            5: begin e.cycles = 3; e.n_imm2 = 2; e.pc_src = 2; end
            6: if (d == SD) begin e.halt = 1; e.cycles = 4; end
               else begin e.cycles = 3; e.n_imm2 = 2; e.n_push = 1; e.pc_src = 2; end
            7: if (d == 0) begin e.halt = 1; e.cycles = 4; end
               else begin e.cycles = 3; e.n_pop = 1; e.pc_src = 3; end
            default: begin e.halt = 1; e.cycles = 3; end
        endcase
        return e;
    endfunction

    // ---------------- monitor ----------------
    int   c_ready, c_irw, c_rd, c_wr, c_reg, c_res, c_alu, c_imm1, c_imm2;
    int   c_push, c_pop, c_aluop, cyc;
    bit   halt_seen;
    exp_t me;

    task automatic clear_counts();
        c_ready = 0; c_irw = 0; c_rd = 0; c_wr = 0; c_reg = 0; c_res = 0;
        c_alu = 0; c_imm1 = 0; c_imm2 = 0; c_push = 0; c_pop = 0; cyc = 0;
    endtask

    initial begin
        clear_counts();
        c_aluop = 0;
        halt_seen = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            clear_counts();
            halt_seen = 0;
        end else begin
            c_ready += int'(instr_ready);
            c_irw   += int'(ir_write);
            c_rd    += int'(mem_read);
            c_wr    += int'(mem_write);
            c_reg   += int'(reg_write);
            c_res   += int'(result_src);
            c_alu   += int'(alu_src);
            c_imm1  += int'(imm_src == 2'b01);
            c_imm2  += int'(imm_src == 2'b10);
            c_push  += int'(stack_push);
            c_pop   += int'(stack_pop);
            c_aluop += int'(alu_op != 2'b00);
            if (instr_ready && instr_valid) cyc = 1;
            else if (cyc != 0) cyc++;

            if (fault) begin
                check("halt strobes", int'({instr_ready, ir_write, pc_write, reg_write,
                      alu_src, mem_read, mem_write, result_src, stack_push, stack_pop,
                      imm_src, pc_src}), 0);
                if (!halt_seen) begin
                    halt_seen = 1;
                    if (exp_q.size() == 0) begin
                        check("unexpected halt", 1, 0);
                    end else begin
                        me = exp_q.pop_front();
                        check("halt expected", 1, int'(me.halt));
                        check("halt cycle", cyc, me.cycles);
                        check("halt push", c_push, 0);
                        check("halt pop", c_pop, 0);
                        check("halt depth", int'(depth), me.depth_pre);
                        check("halt ir_write", c_irw, 1);
                    end
                end
            end

            if (pc_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected pc_write", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    check("retire not halt", int'(me.halt), 0);
                    check("cycles", cyc, me.cycles);
                    check("pc_src", int'(pc_src), me.pc_src);
                    check("instr_ready cycles", c_ready, me.n_ready);
                    check("ir_write cycles", c_irw, me.n_irw);
                    check("mem_read cycles", c_rd, me.n_rd);
                    check("mem_write cycles", c_wr, me.n_wr);
                    check("reg_write cycles", c_reg, me.n_reg);
                    check("result_src cycles", c_res, me.n_res);
                    check("alu_src cycles", c_alu, me.n_alu);
                    check("imm01 cycles", c_imm1, me.n_imm1);
                    check("imm10 cycles", c_imm2, me.n_imm2);
                    check("push cycles", c_push, me.n_push);
                    check("pop cycles", c_pop, me.n_pop);
                    check("depth at retire", int'(depth), me.depth_pre);
                end
                clear_counts();
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit v, input logic [OP_W-1:0] o,
                               input bit z, input bit mr);
        instr_valid = v;
        op          = o;
        zero        = z;
        mem_ready   = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("reset depth", int'(depth), 0);
        check("reset fault", int'(fault), 0);
        check("reset instr_ready", int'(instr_ready), 1);
        check("reset stack_push", int'(stack_push), 0);
        check("reset pc_write", int'(pc_write), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_depth = 0;
    endtask

    // Issue one instruction: s fetch-stall cycles, w memory wait cycles,
    // zero flag z in EXEC. abort_at>0 resets at that cycle; hold is the
    // number of cycles spent halted before reset when a halt is expected.
    task automatic issue(input int opc, input int s, input int w, input bit z,
                         input int abort_at, input int hold);
        exp_t e;
        int   ncyc;
        bit   mr;
        e = model(opc, s, w, z, model_depth);
        ncyc = e.halt ? e.cycles - 1 : e.cycles;
        if (abort_at == 0) exp_q.push_back(e);
        repeat (s) drive_cycle(1'b0, OP_W'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 1; k <= ncyc; k++) begin
            if (abort_at == k) begin
                do_reset();
                return;
            end
            if ((opc == 1 || opc == 2) && k >= 4) mr = (k >= 4 + w);
            else mr = 1'($urandom);
            drive_cycle((k == 1) ? 1'b1 : 1'($urandom),
                        (k == 1) ? OP_W'(opc) : OP_W'($urandom),
                        (k == 3) ? z : 1'($urandom), mr);
        end
        if (e.halt) begin
            repeat (hold) drive_cycle(1'b1, OP_W'($urandom), 1'($urandom), 1'($urandom));
            do_reset();
        end else begin
            if (opc == 6) model_depth++;
            if (opc == 7) model_depth--;
        end
    endtask

    initial begin
        int opc, ncyc_r, ab;
        rst = 1'b1;
        instr_valid = 1'b0;
        op = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #3;
        check("por instr_ready", int'(instr_ready), 1);
        check("por ir_write idle", int'(ir_write), 0);
        check("por depth", int'(depth), 0);
        check("por fault", int'(fault), 0);
        check("por pc_write", int'(pc_write), 0);
        instr_valid = 1'b1;
        #1;
        check("por ir_write valid", int'(ir_write), 1);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R, LOAD with two wait cycles, branches both ways, JMP, stalled STORE
        issue(0, 0, 0, 0, 0, 0);
        issue(1, 0, 2, 0, 0, 0);
        issue(3, 0, 0, 1, 0, 0);
        issue(3, 0, 0, 0, 0, 0);
        issue(4, 0, 0, 1, 0, 0);
        issue(4, 0, 0, 0, 0, 0);
        issue(5, 1, 0, 0, 0, 0);
        issue(2, 5, 1, 0, 0, 0);
        // reset in EXEC of a CALL at depth 3
        issue(6, 0, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 3, 0);
        // fill the stack, overflow, then underflow, then illegal opcode
        repeat (SD) issue(6, 0, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 0, 4);
        issue(7, 0, 0, 0, 0, 4);
        issue(8, 0, 0, 0, 0, 20);
        issue(6, 0, 0, 0, 0, 0);
        issue(7, 2, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 99) < 4) opc = 8 + int'($urandom_range(0, 23));
            else opc = int'($urandom_range(0, 7));
            ab = 0;
            if (opc <= 5 && $urandom_range(0, 24) == 0) begin
                ncyc_r = model(opc, 0, 1, 1'b0, model_depth).cycles;
                ab = int'($urandom_range(2, ncyc_r));
                issue(opc, int'($urandom_range(0, 2)), 1, 1'($urandom), ab, 0);
            end else begin
                issue(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), 0, int'($urandom_range(1, 3)));
            end
        end

        repeat (5) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        check("final depth", int'(depth), model_depth);
        check("scoreboard drained", exp_q.size(), 0);
        check("alu_op nonzero cycles", c_aluop, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
